mmu_utlb: RTL and testbench
===========================

Name: mmu_utlb

Overview:
- Next-generation address translator for the MIPS core.
- Keeps fixed kseg0/kseg1 direct mapping and the user-mode kernel-address check.
- Adds a parametrised fully-associative micro-TLB for kuseg/kseg2/kseg3, with a refill handshake to the shared main TLB.
- Sits between a fetch or LSU request port and the cache; one translation in flight.

Parameters:
- ENTRIES, 4: micro-TLB entry count; power of two, 2..16.
- ASID_W, 8: ASID width.
- VPN_W, 20: virtual page number width (4 KB pages, vaddr[31:12]).
- PFN_W, 20: physical frame number width; paddr = {pfn, vaddr[11:0]}.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  translation request
- req_ready  out  1  block can accept a request
- req_vaddr  in  32  virtual address
- req_is_store  in  1  store access
- user_mode  in  1  CPU in user mode
- asid  in  ASID_W  current ASID
- cp0_kseg0_uncached  in  1  kseg0 cacheability (1 = uncached)
- flush  in  1  invalidate all micro-TLB entries
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- resp_paddr  out  32  physical address (0 when resp_exc != 0)
- resp_uncached  out  1  uncached access
- resp_exc  out  3  0 none, 1 addr_err, 2 tlb_refill, 3 tlb_invalid, 4 tlb_modified
- refill_valid  out  1  micro-TLB miss, request to main TLB
- refill_vpn  out  VPN_W  missing VPN
- refill_asid  out  ASID_W  ASID of the miss
- refill_done  in  1  main TLB answer valid (single-cycle pulse)
- refill_hit  in  1  main TLB found a matching entry
- refill_pfn  in  PFN_W  frame number
- refill_g  in  1  global bit
- refill_v  in  1  valid bit
- refill_d  in  1  dirty/writable bit
- refill_c  in  1  uncached attribute

Behaviour:
- Reset: clock is clk; reset is rst, synchronous and active-high.
  - State goes to IDLE; all entries invalid; round-robin pointer rr = 0.
  - req_ready = 1; resp_valid = 0, resp_paddr = 0, resp_uncached = 0, resp_exc = 0.
  - refill_valid = 0, refill_vpn = 0, refill_asid = 0.
  - rst during any state aborts the operation; no response is produced.
- FSM states: IDLE, LOOKUP, REFILL, RESP.
  - IDLE: req_ready = 1. Handshake req_valid & req_ready captures vaddr, store, user_mode, asid and kseg0 attribute, then moves to LOOKUP.
  - LOOKUP (1 cycle, req_ready = 0), first matching rule applies:
    - user_mode & vaddr[31]: exc 1 -> RESP.
    - vaddr[31:29] = 100: paddr = {3'b0, vaddr[28:0]}, uncached = captured cp0_kseg0_uncached -> RESP.
    - vaddr[31:29] = 101: same paddr, uncached = 1 -> RESP.
    - Otherwise: parallel compare. Hit = entry valid & VPN equal & (G | ASID equal); lowest index wins on multiple hits.
      - Hit, V = 0: exc 3.
      - Hit, store & D = 0: exc 4.
      - Hit, no exception: paddr = {pfn, vaddr[11:0]}, uncached = C.
      - Hit goes to RESP; miss goes to REFILL.
  - REFILL: refill_valid = 1, with vpn/asid held stable until the cycle refill_done = 1.
    - refill_hit = 1: write entry[rr], advance rr (wraps ENTRIES-1 -> 0), form the response from the refill fields with the same V/D checks -> RESP.
    - refill_hit = 0: no write, exc 2 -> RESP.
  - RESP: outputs registered and held stable while resp_valid = 1 & resp_ready = 0. On resp_ready, go to IDLE.
- Latency, counted from the accept cycle T:
  - Direct-mapped, hit or exception: resp_valid at T+2.
  - Miss: resp_valid 1 cycle after refill_done.
  - Maximum throughput: 1 request per 3 cycles.
- Flush:
  - Clears all valid bits at the clock edge; rr unchanged.
  - Flush coincident with a refill write: flush wins, entry not written, response still delivered.
  - Flush in LOOKUP: lookup uses the pre-flush contents.
- The micro-TLB does not update on its own; CP0 TLB writes must be followed by flush.

Optional Feature:
- Macro: MMU_UTLB_PERF_EN.
- Defined:
  - Adds outputs perf_hit_cnt (32, out) and perf_miss_cnt (32, out).
  - Each counts once per LOOKUP that takes the mapped path: hit or miss respectively.
  - Both cleared by rst, wrap at 2^32, unaffected by flush.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- kseg0/kseg1: vaddr 0x8000_1234 with cp0_kseg0_uncached = 1 -> paddr 0x0000_1234, uncached 1, exc 0, resp_valid at T+2. Then vaddr 0xA000_0010 -> paddr 0x0000_0010, uncached 1.
- Address error: user_mode = 1, vaddr 0xBFC0_0000 -> exc 1, paddr 0, refill_valid never asserted.
- Miss then hit: vaddr 0x0040_0ABC, asid 5 -> refill_valid with vpn 0x00400, asid 5. Reply hit, pfn 0x1F000, V = 1, D = 1, C = 0 -> paddr 0x1F00_0ABC. Repeat the request -> hit, no refill, resp at T+2.
- Exceptions: store to a page refilled with D = 0 -> exc 4. Page with V = 0 -> exc 3. Refill reply with refill_hit = 0 -> exc 2, entry not written; the next same access misses again.
- Replacement and flush: fill ENTRIES + 1 distinct pages -> the first page is evicted (rr wrap) and misses again. Assert flush in the refill_done cycle -> the next same access misses.
- Back-pressure and reset: hold resp_ready = 0 for 5 cycles -> outputs stable, req_ready = 0. Assert rst in REFILL -> next cycle IDLE, refill_valid = 0, all entries invalid.

Source files
------------

// File: rtl/mmu_utlb.sv
// mmu_utlb: virtual-to-physical address translator for the MIPS core.
//
// kseg0/kseg1 are translated by direct mapping. A user-mode access to any
// kernel address raises an address error. kuseg/kseg2/kseg3 go through a
// fully-associative micro-TLB. A micro-TLB miss asks the shared main TLB
// for the entry over the refill handshake. Only one translation is in
// flight at a time.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_*               request: valid/ready, vaddr, store flag
//   user_mode, asid     CPU mode and current ASID, captured with the request
//   cp0_kseg0_uncached  kseg0 cacheability, captured with the request
//   flush               invalidate every micro-TLB entry
//   resp_*              result: valid/ready, paddr, uncached, exception code
//                       (0 none, 1 addr_err, 2 tlb_refill, 3 tlb_invalid,
//                        4 tlb_modified)
//   refill_valid/vpn/asid  miss request to the main TLB
//   refill_done/hit/pfn/g/v/d/c  main TLB answer (done is a one-cycle pulse)
//
// Optional build macro MMU_UTLB_PERF_EN adds the outputs perf_hit_cnt and
// perf_miss_cnt. These count micro-TLB hits and misses on the mapped path.
module mmu_utlb #(
    parameter int ENTRIES = 4,
    parameter int ASID_W  = 8,
    parameter int VPN_W   = 20,
    parameter int PFN_W   = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_vaddr,
    input  logic              req_is_store,
    input  logic              user_mode,
    input  logic [ASID_W-1:0] asid,
    input  logic              cp0_kseg0_uncached,
    input  logic              flush,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_paddr,
    output logic              resp_uncached,
    output logic [2:0]        resp_exc,
    output logic              refill_valid,
    output logic [VPN_W-1:0]  refill_vpn,
    output logic [ASID_W-1:0] refill_asid,
    input  logic              refill_done,
    input  logic              refill_hit,
    input  logic [PFN_W-1:0]  refill_pfn,
    input  logic              refill_g,
    input  logic              refill_v,
    input  logic              refill_d,
    input  logic              refill_c
`ifdef MMU_UTLB_PERF_EN
    ,
    output logic [31:0]       perf_hit_cnt,
    output logic [31:0]       perf_miss_cnt
`endif
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    localparam logic [2:0] EXC_NONE     = 3'd0;
    localparam logic [2:0] EXC_ADDR_ERR = 3'd1;
    localparam logic [2:0] EXC_REFILL   = 3'd2;
    localparam logic [2:0] EXC_INVALID  = 3'd3;
    localparam logic [2:0] EXC_MODIFIED = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL, S_RESP} state_t;

    typedef struct packed {
        logic [2:0]  exc;
        logic [31:0] paddr;
        logic        unc;
    } resp_t;

    // Builds a mapped-page response. V and D are checked here. When an
    // exception is raised, paddr and uncached are forced to zero.
    function automatic resp_t form_resp(input logic [PFN_W-1:0] pfn,
                                        input logic v, input logic d,
                                        input logic c, input logic store,
                                        input logic [11:0] offset);
        resp_t r;
        r.exc   = EXC_NONE;
        r.paddr = 32'({pfn, offset});
        r.unc   = c;
        if (!v) begin
            r.exc = EXC_INVALID;
        end else if (store && !d) begin
            r.exc = EXC_MODIFIED;
        end
        if (r.exc != EXC_NONE) begin
            r.paddr = '0;
            r.unc   = 1'b0;
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [31:0]         vaddr_q, vaddr_d;
    logic                store_q, store_d;
    logic                user_q, user_d;
    logic [ASID_W-1:0]   asid_q, asid_d;
    logic                kseg0_unc_q, kseg0_unc_d;
    logic [31:0]         resp_paddr_q, resp_paddr_d;
    logic                resp_unc_q, resp_unc_d;
    logic [2:0]          resp_exc_q, resp_exc_d;
    logic [VPN_W-1:0]    refill_vpn_q, refill_vpn_d;
    logic [ASID_W-1:0]   refill_asid_q, refill_asid_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic                ent_we;

    // Entry payload. Only the valid bits need a reset.
    logic [VPN_W-1:0]    ent_vpn_q  [ENTRIES];
    logic [ASID_W-1:0]   ent_asid_q [ENTRIES];
    logic [PFN_W-1:0]    ent_pfn_q  [ENTRIES];
    logic [ENTRIES-1:0]  ent_g_q, ent_v_q, ent_d_q, ent_c_q;

    logic                hit;
    logic [IDX_W-1:0]    hit_idx;

`ifdef MMU_UTLB_PERF_EN
    logic [31:0]         perf_hit_q, perf_hit_d;
    logic [31:0]         perf_miss_q, perf_miss_d;
    assign perf_hit_cnt  = perf_hit_q;
    assign perf_miss_cnt = perf_miss_q;
`endif

    assign req_ready     = (state_q == S_IDLE);
    assign resp_valid    = (state_q == S_RESP);
    assign refill_valid  = (state_q == S_REFILL);
    assign resp_paddr    = resp_paddr_q;
    assign resp_uncached = resp_unc_q;
    assign resp_exc      = resp_exc_q;
    assign refill_vpn    = refill_vpn_q;
    assign refill_asid   = refill_asid_q;

    // Parallel compare. The scan runs downward so that the lowest matching
    // index is the one left in hit_idx.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && (ent_vpn_q[i] == vaddr_q[31:12]) &&
                (ent_g_q[i] || (ent_asid_q[i] == asid_q))) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        resp_t r;
        state_d       = state_q;
        vaddr_d       = vaddr_q;
        store_d       = store_q;
        user_d        = user_q;
        asid_d        = asid_q;
        kseg0_unc_d   = kseg0_unc_q;
        resp_paddr_d  = resp_paddr_q;
        resp_unc_d    = resp_unc_q;
        resp_exc_d    = resp_exc_q;
        refill_vpn_d  = refill_vpn_q;
        refill_asid_d = refill_asid_q;
        rr_d          = rr_q;
        valid_d       = valid_q;
        ent_we        = 1'b0;
        r             = '0;
`ifdef MMU_UTLB_PERF_EN
        perf_hit_d    = perf_hit_q;
        perf_miss_d   = perf_miss_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    vaddr_d     = req_vaddr;
                    store_d     = req_is_store;
                    user_d      = user_mode;
                    asid_d      = asid;
                    kseg0_unc_d = cp0_kseg0_uncached;
                    state_d     = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                state_d = S_RESP;
                if (user_q && vaddr_q[31]) begin
                    resp_exc_d   = EXC_ADDR_ERR;
                    resp_paddr_d = '0;
                    resp_unc_d   = 1'b0;
                end else if (vaddr_q[31:30] == 2'b10) begin
                    // kseg0 (100) and kseg1 (101) strip the top three bits.
                    resp_exc_d   = EXC_NONE;
                    resp_paddr_d = {3'b000, vaddr_q[28:0]};
                    resp_unc_d   = vaddr_q[29] ? 1'b1 : kseg0_unc_q;
                end else if (hit) begin
                    r = form_resp(ent_pfn_q[hit_idx], ent_v_q[hit_idx],
                                  ent_d_q[hit_idx], ent_c_q[hit_idx],
                                  store_q, vaddr_q[11:0]);
                    resp_exc_d   = r.exc;
                    resp_paddr_d = r.paddr;
                    resp_unc_d   = r.unc;
`ifdef MMU_UTLB_PERF_EN
                    perf_hit_d   = perf_hit_q + 32'd1;
`endif
                end else begin
                    refill_vpn_d  = vaddr_q[31:12];
                    refill_asid_d = asid_q;
                    state_d       = S_REFILL;
`ifdef MMU_UTLB_PERF_EN
                    perf_miss_d   = perf_miss_q + 32'd1;
`endif
                end
            end
            S_REFILL: begin
                if (refill_done) begin
                    state_d = S_RESP;
                    if (refill_hit) begin
                        r = form_resp(refill_pfn, refill_v, refill_d, refill_c,
                                      store_q, vaddr_q[11:0]);
                        resp_exc_d   = r.exc;
                        resp_paddr_d = r.paddr;
                        resp_unc_d   = r.unc;
                        // A coincident flush cancels the write. The victim
                        // pointer then stays put, because nothing was written.
                        if (!flush) begin
                            ent_we         = 1'b1;
                            valid_d[rr_q]  = 1'b1;
                            rr_d           = (rr_q == IDX_W'(ENTRIES - 1)) ?
                                             '0 : rr_q + 1'b1;
                        end
                    end else begin
                        resp_exc_d   = EXC_REFILL;
                        resp_paddr_d = '0;
                        resp_unc_d   = 1'b0;
                    end
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush overrides any valid bit that the refill path set this cycle.
        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            vaddr_q       <= '0;
            store_q       <= 1'b0;
            user_q        <= 1'b0;
            asid_q        <= '0;
            kseg0_unc_q   <= 1'b0;
            resp_paddr_q  <= '0;
            resp_unc_q    <= 1'b0;
            resp_exc_q    <= '0;
            refill_vpn_q  <= '0;
            refill_asid_q <= '0;
            rr_q          <= '0;
            valid_q       <= '0;
`ifdef MMU_UTLB_PERF_EN
            perf_hit_q    <= '0;
            perf_miss_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            vaddr_q       <= vaddr_d;
            store_q       <= store_d;
            user_q        <= user_d;
            asid_q        <= asid_d;
            kseg0_unc_q   <= kseg0_unc_d;
            resp_paddr_q  <= resp_paddr_d;
            resp_unc_q    <= resp_unc_d;
            resp_exc_q    <= resp_exc_d;
            refill_vpn_q  <= refill_vpn_d;
            refill_asid_q <= refill_asid_d;
            rr_q          <= rr_d;
            valid_q       <= valid_d;
`ifdef MMU_UTLB_PERF_EN
            perf_hit_q    <= perf_hit_d;
            perf_miss_q   <= perf_miss_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (ent_we) begin
            ent_vpn_q[rr_q]  <= refill_vpn_q;
            ent_asid_q[rr_q] <= refill_asid_q;
            ent_pfn_q[rr_q]  <= refill_pfn;
            ent_g_q[rr_q]    <= refill_g;
            ent_v_q[rr_q]    <= refill_v;
            ent_d_q[rr_q]    <= refill_d;
            ent_c_q[rr_q]    <= refill_c;
        end
    end

endmodule

// File: tb/tb_mmu_utlb.sv
// Testbench for mmu_utlb. The bench first runs directed steps and then
// random transactions. Every transaction is predicted by a reference
// micro-TLB model: an array of entries, a FIFO victim index and the
// translation rules.
module tb_mmu_utlb;

    localparam int ENTRIES = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_vaddr = '0;
    logic        req_is_store = 1'b0;
    logic        user_mode = 1'b0;
    logic [7:0]  asid = '0;
    logic        cp0_kseg0_uncached = 1'b0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_paddr;
    logic        resp_uncached;
    logic [2:0]  resp_exc;
    logic        refill_valid;
    logic [19:0] refill_vpn;
    logic [7:0]  refill_asid;
    logic        refill_done = 1'b0;
    logic        refill_hit = 1'b0;
    logic [19:0] refill_pfn = '0;
    logic        refill_g = 1'b0;
    logic        refill_v = 1'b0;
    logic        refill_d = 1'b0;
    logic        refill_c = 1'b0;

    mmu_utlb #(.ENTRIES(ENTRIES), .ASID_W(8), .VPN_W(20), .PFN_W(20)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
        .req_is_store(req_is_store), .user_mode(user_mode), .asid(asid),
        .cp0_kseg0_uncached(cp0_kseg0_uncached), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_paddr(resp_paddr), .resp_uncached(resp_uncached),
        .resp_exc(resp_exc),
        .refill_valid(refill_valid), .refill_vpn(refill_vpn),
        .refill_asid(refill_asid), .refill_done(refill_done),
        .refill_hit(refill_hit), .refill_pfn(refill_pfn),
        .refill_g(refill_g), .refill_v(refill_v), .refill_d(refill_d),
        .refill_c(refill_c)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference micro-TLB contents.
    logic        m_val  [ENTRIES];
    logic [19:0] m_vpn  [ENTRIES];
    logic [7:0]  m_asid [ENTRIES];
    logic [19:0] m_pfn  [ENTRIES];
    logic        m_g [ENTRIES];
    logic        m_v [ENTRIES];
    logic        m_d [ENTRIES];
    logic        m_c [ENTRIES];
    int          m_rr = 0;

    logic        last_miss;
    logic [2:0]  last_exc;
    logic [31:0] last_paddr;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < ENTRIES; i++) m_val[i] = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_clear();
    endtask

    // One complete translation. It is entered and left #1 after a rising edge,
    // with the DUT idle at both points.
    task automatic xact(input logic [31:0] va, input logic st, input logic um,
                        input logic [7:0] as, input logic ku,
                        input logic r_hit, input logic [19:0] r_pfn,
                        input logic r_g, input logic r_v, input logic r_d,
                        input logic r_c, input logic fl_at_done,
                        input int refill_wait, input int hold);
        logic        e_miss, a_v, a_d, a_c, e_unc;
        logic [19:0] a_pfn;
        logic [2:0]  e_exc;
        logic [31:0] e_pa;
        int          idx;
        e_miss = 1'b0; e_exc = 3'd0; e_pa = '0; e_unc = 1'b0;
        a_v = 1'b0; a_d = 1'b0; a_c = 1'b0; a_pfn = '0; idx = -1;

        if (um && va[31]) begin
            e_exc = 3'd1;
        end else if (va >= 32'h8000_0000 && va < 32'hC000_0000) begin
            e_pa  = va - (va >= 32'hA000_0000 ? 32'hA000_0000 : 32'h8000_0000);
            e_unc = (va >= 32'hA000_0000) ? 1'b1 : ku;
        end else begin
            for (int i = 0; i < ENTRIES; i++)
                if (idx < 0 && m_val[i] && m_vpn[i] == va[31:12] &&
                    (m_g[i] || m_asid[i] == as)) idx = i;
            if (idx >= 0) begin
                a_pfn = m_pfn[idx]; a_v = m_v[idx]; a_d = m_d[idx]; a_c = m_c[idx];
            end else begin
                e_miss = 1'b1;
                a_pfn = r_pfn; a_v = r_v; a_d = r_d; a_c = r_c;
            end
            if (e_miss && !r_hit)      e_exc = 3'd2;
            else if (!a_v)             e_exc = 3'd3;
            else if (st && !a_d)       e_exc = 3'd4;
            else begin
                e_pa  = {a_pfn, 12'h000} + {20'h0, va[11:0]};
                e_unc = a_c;
            end
        end

        chk("idle_req_ready", req_ready, 1);
        req_valid = 1'b1; req_vaddr = va; req_is_store = st; user_mode = um;
        asid = as; cp0_kseg0_uncached = ku;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_vaddr = $urandom; user_mode = ~um; asid = ~as; cp0_kseg0_uncached = ~ku;
        chk("lookup_req_ready", req_ready, 0);
        chk("lookup_resp_valid", resp_valid, 0);
        @(posedge clk); #1;
        if (e_miss) begin
            chk("miss_resp_valid", resp_valid, 0);
            chk("refill_valid", refill_valid, 1);
            chk("refill_vpn", refill_vpn, va[31:12]);
            chk("refill_asid", refill_asid, as);
            for (int w = 0; w < refill_wait; w++) begin
                @(posedge clk); #1;
                chk("refill_valid_hold", refill_valid, 1);
                chk("refill_vpn_hold", refill_vpn, va[31:12]);
            end
            refill_done = 1'b1; refill_hit = r_hit; refill_pfn = r_pfn;
            refill_g = r_g; refill_v = r_v; refill_d = r_d; refill_c = r_c;
            flush = fl_at_done;
            @(posedge clk); #1;
            refill_done = 1'b0; flush = 1'b0; refill_hit = $urandom;
            refill_pfn = $urandom;
            if (r_hit && !fl_at_done) begin
                m_val[m_rr] = 1'b1; m_vpn[m_rr] = va[31:12]; m_asid[m_rr] = as;
                m_pfn[m_rr] = r_pfn; m_g[m_rr] = r_g; m_v[m_rr] = r_v;
                m_d[m_rr] = r_d; m_c[m_rr] = r_c;
                m_rr = (m_rr + 1) % ENTRIES;
            end
            if (fl_at_done) model_clear();
            chk("after_refill_valid", refill_valid, 0);
        end else begin
            chk("no_refill_valid", refill_valid, 0);
        end
        chk("resp_valid", resp_valid, 1);
        chk("resp_paddr", resp_paddr, e_pa);
        chk("resp_uncached", resp_uncached, e_unc);
        chk("resp_exc", resp_exc, e_exc);
        last_miss = e_miss; last_exc = resp_exc; last_paddr = resp_paddr;
        resp_ready = (hold == 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("bp_resp_valid", resp_valid, 1);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_paddr", resp_paddr, e_pa);
            chk("bp_exc", resp_exc, e_exc);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("resp_done", resp_valid, 0);
    endtask

    initial begin
        logic [19:0] pool [8];
        pool = '{20'h00400, 20'h00401, 20'h00402, 20'h00403,
                 20'h00404, 20'hC0000, 20'hE0010, 20'h7FFFF};
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_paddr", resp_paddr, 0);
        chk("rst_uncached", resp_uncached, 0);
        chk("rst_exc", resp_exc, 0);
        chk("rst_refill_valid", refill_valid, 0);
        chk("rst_refill_vpn", refill_vpn, 0);
        chk("rst_refill_asid", refill_asid, 0);

        // Direct-mapped segments.
        xact(32'h8000_1234, 0, 0, 8'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("kseg0_paddr", last_paddr, 32'h0000_1234);
        xact(32'hA000_0010, 0, 0, 8'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("kseg1_paddr", last_paddr, 32'h0000_0010);
        // User access to a kernel address.
        xact(32'hBFC0_0000, 0, 1, 8'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("addr_err_exc", last_exc, 3'd1);
        // Miss, then hit.
        xact(32'h0040_0ABC, 0, 0, 8'd5, 0, 1, 20'h1F000, 0, 1, 1, 0, 0, 2, 0);
        chk("miss_first", last_miss, 1);
        chk("miss_paddr", last_paddr, 32'h1F00_0ABC);
        xact(32'h0040_0ABC, 0, 0, 8'd5, 0, 1, 20'h12345, 0, 1, 1, 0, 0, 0, 0);
        chk("hit_second", last_miss, 0);
        chk("hit_paddr", last_paddr, 32'h1F00_0ABC);
        // Store to a clean page, then an invalid page, then a main TLB miss.
        xact(32'h0041_0000, 1, 0, 8'd5, 0, 1, 20'h00222, 0, 1, 0, 1, 0, 0, 0);
        chk("modified_exc", last_exc, 3'd4);
        xact(32'h0041_0004, 0, 0, 8'd5, 0, 1, 20'h0, 0, 1, 1, 0, 0, 0, 0);
        chk("clean_load_exc", last_exc, 3'd0);
        xact(32'h0042_0000, 0, 0, 8'd5, 0, 1, 20'h00333, 0, 0, 1, 0, 0, 1, 0);
        chk("invalid_exc", last_exc, 3'd3);
        xact(32'h0043_0000, 0, 0, 8'd5, 0, 0, 20'h00444, 0, 1, 1, 0, 0, 0, 0);
        chk("refill_miss_exc", last_exc, 3'd2);
        xact(32'h0043_0000, 0, 0, 8'd5, 0, 1, 20'h00444, 0, 1, 1, 0, 0, 0, 0);
        chk("refill_miss_again", last_miss, 1);
        // Replacement: ENTRIES + 1 distinct pages evict the first one.
        do_flush();
        for (int i = 0; i <= ENTRIES; i++)
            xact(32'h0050_0000 + (i << 12), 0, 0, 8'd7, 0, 1, 20'h00A00 + 20'(i),
                 0, 1, 1, 0, 0, 0, 0);
        xact(32'h0050_1000, 0, 0, 8'd7, 0, 1, 20'h0, 0, 1, 1, 0, 0, 0, 0);
        chk("second_page_hit", last_miss, 0);
        xact(32'h0050_0000, 0, 0, 8'd7, 0, 1, 20'h00B00, 0, 1, 1, 0, 0, 0, 0);
        chk("evicted_page_miss", last_miss, 1);
        // Flush in the refill_done cycle.
        xact(32'h0060_0000, 0, 0, 8'd7, 0, 1, 20'h00C00, 0, 1, 1, 0, 1, 0, 0);
        chk("flush_refill_paddr", last_paddr, 32'h00C0_0000);
        xact(32'h0060_0000, 0, 0, 8'd7, 0, 1, 20'h00C00, 0, 1, 1, 0, 0, 0, 0);
        chk("flush_refill_miss", last_miss, 1);
        // Back-pressure.
        xact(32'h8000_0040, 0, 0, 8'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
        // Reset while waiting in REFILL.
        req_valid = 1'b1; req_vaddr = 32'h0070_0000; asid = 8'd9; user_mode = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_refill_valid", refill_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        m_rr = 0;
        chk("rst_refill_ready", req_ready, 1);
        chk("rst_refill_refill_valid", refill_valid, 0);
        chk("rst_refill_resp_valid", resp_valid, 0);
        xact(32'h0060_0000, 0, 0, 8'd7, 0, 1, 20'h00D00, 0, 1, 1, 0, 0, 0, 0);
        chk("rst_entries_invalid", last_miss, 1);

        // Random transactions.
        for (int n = 0; n < 80; n++) begin
            logic [31:0] va;
            if ($urandom_range(0, 7) == 0)
                va = {($urandom_range(0, 1) ? 3'b101 : 3'b100), 29'($urandom)};
            else
                va = {pool[$urandom_range(0, 7)], 12'($urandom)};
            if ($urandom_range(0, 15) == 0) do_flush();
            xact(va, 1'($urandom), ($urandom_range(0, 3) == 0),
                 8'($urandom_range(1, 3)), 1'($urandom),
                 ($urandom_range(0, 4) != 0), 20'($urandom), 1'($urandom),
                 ($urandom_range(0, 5) != 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 9) == 0), $urandom_range(0, 3),
                 $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
